// File: rtl/calc_req_scheduler.sv
// ============================================================================
// Module  : calc_req_scheduler
// Brief   : Round-robin scheduler serialising 4 calculator requesters onto a
//           two-beat packet bus, with tagged response routing and timeouts.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_req_scheduler #(
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req_valid,
  input  logic [15:0]  req_cmd,
  input  logic [127:0] req_op1,
  input  logic [127:0] req_op2,
  output logic [3:0]   req_ready,
  output logic [37:0]  paket_out,
  input  logic         rsp_in_valid,
  input  logic [1:0]   rsp_in_tag,
  input  logic [1:0]   rsp_in_resp,
  input  logic [31:0]  rsp_in_data,
  output logic [3:0]   rsp_valid,
  output logic [7:0]   rsp_resp,
  output logic [127:0] rsp_data,
  output logic [3:0]   busy,
  output logic         stray_rsp
);

  localparam logic [1:0]  c_IDLE     = 2'd0;
  localparam logic [1:0]  c_BEAT0    = 2'd1;
  localparam logic [1:0]  c_BEAT1    = 2'd2;
  localparam logic [1:0]  c_GAP      = 2'd3;
  localparam logic [3:0]  c_GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic        c_NO_GAP   = (GAP_CYCLES == 0);
  localparam logic        c_TO_ONE   = (TIMEOUT == 1);

  logic [1:0]   r_state;
  logic [3:0]   r_gap;
  logic [1:0]   r_rr;
  logic [1:0]   r_g;
  logic [31:0]  r_op2;
  logic [37:0]  r_paket;
  logic [3:0]   r_busy;
  logic [3:0]   r_rsp_valid;
  logic [7:0]   r_rsp_resp;
  logic [127:0] r_rsp_data;
  logic         r_stray;
  logic [15:0]  r_tmr [4];
  logic [3:0]   r_tmr_on;

  logic [3:0]   w_elig;
  logic [3:0]   w_tstart;
  logic [3:0]   w_to;
  logic [1:0]   w_gidx;
  logic [1:0]   w_idx;
  logic         w_found;
  logic         w_slot;
  logic         w_grant;
  logic         w_rsp_hit;
  logic [31:0]  w_op1;
  logic [31:0]  w_op2;
  logic [3:0]   w_cmd;

  always_comb begin
    w_elig = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      w_elig[p] = req_valid[p] & ~r_busy[p] & (req_cmd[4*p +: 4] != 4'h0);
    end
  end

  // First eligible port at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_gidx  = 2'd0;
    w_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rr + 2'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
  end

  // A grant slot also opens in BEAT1 (no gap) or the last GAP cycle so that
  // back-to-back packets keep the bus busy without an idle cycle.
  assign w_slot    = (r_state == c_IDLE)
                   | (c_NO_GAP & (r_state == c_BEAT1))
                   | ((r_state == c_GAP) & (r_gap == c_GAP_LAST));
  assign w_grant   = w_slot & w_found;
  assign req_ready = w_grant ? (4'b0001 << w_gidx) : 4'b0000;
  assign w_op1     = req_op1[32*w_gidx +: 32];
  assign w_op2     = req_op2[32*w_gidx +: 32];
  assign w_cmd     = req_cmd[4*w_gidx +: 4];
  assign w_rsp_hit = rsp_in_valid & r_busy[rsp_in_tag];

  always_comb begin
    w_tstart = 4'b0000;
    w_to     = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      w_tstart[p] = (r_state == c_BEAT1) & (r_g == 2'(p)) & r_busy[p]
                  & ~(rsp_in_valid & (rsp_in_tag == 2'(p)));
      w_to[p]     = r_busy[p] & ((r_tmr_on[p] & (r_tmr[p] == c_TO_LAST))
                  | (c_TO_ONE & w_tstart[p]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_gap   <= 4'd0;
      r_rr    <= 2'd0;
      r_g     <= 2'd0;
      r_op2   <= 32'd0;
      r_paket <= 38'd0;
    end else begin
      if (w_grant) begin
        r_g     <= w_gidx;
        r_op2   <= w_op2;
        r_rr    <= w_gidx + 2'd1;
        r_paket <= {w_op1, w_cmd, w_gidx};
      end else if (r_state == c_BEAT0) begin
        r_paket <= {r_op2, 6'h00};
      end else begin
        r_paket <= 38'd0;
      end
      case (r_state)
        c_IDLE:  if (w_grant) r_state <= c_BEAT0;
        c_BEAT0: r_state <= c_BEAT1;
        c_BEAT1: begin
          if (!c_NO_GAP) begin
            r_state <= c_GAP;
            r_gap   <= 4'd0;
          end else begin
            r_state <= w_grant ? c_BEAT0 : c_IDLE;
          end
        end
        c_GAP: begin
          if (r_gap == c_GAP_LAST) r_state <= w_grant ? c_BEAT0 : c_IDLE;
          else                     r_gap   <= r_gap + 4'd1;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Timer is preloaded with 1 because the BEAT1 cycle itself is tick zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= 4'b0000;
      r_rsp_valid <= 4'b0000;
      r_rsp_resp  <= 8'd0;
      r_rsp_data  <= 128'd0;
      r_stray     <= 1'b0;
      r_tmr_on    <= 4'b0000;
      for (int p = 0; p < 4; p++) r_tmr[p] <= 16'd0;
    end else begin
      r_stray     <= rsp_in_valid & ~r_busy[rsp_in_tag];
      r_rsp_valid <= 4'b0000;
      for (int p = 0; p < 4; p++) begin
        if (w_rsp_hit && (rsp_in_tag == 2'(p))) begin
          r_rsp_valid[p]       <= 1'b1;
          r_rsp_resp[2*p +: 2] <= rsp_in_resp;
          r_rsp_data[32*p +: 32] <= rsp_in_data;
          r_busy[p]            <= 1'b0;
          r_tmr_on[p]          <= 1'b0;
        end else if (w_to[p]) begin
          r_rsp_valid[p]       <= 1'b1;
          r_rsp_resp[2*p +: 2] <= 2'b11;
          r_rsp_data[32*p +: 32] <= 32'd0;
          r_busy[p]            <= 1'b0;
          r_tmr_on[p]          <= 1'b0;
        end else begin
          if (w_grant && (w_gidx == 2'(p))) r_busy[p] <= 1'b1;
          if (w_tstart[p]) begin
            r_tmr_on[p] <= 1'b1;
            r_tmr[p]    <= 16'd1;
          end else if (r_tmr_on[p]) begin
            r_tmr[p]    <= r_tmr[p] + 16'd1;
          end
        end
      end
    end
  end

  assign paket_out = r_paket;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_resp  = r_rsp_resp;
  assign rsp_data  = r_rsp_data;
  assign stray_rsp = r_stray;

endmodule

`default_nettype wire

// File: tb/tb_calc_req_scheduler.sv
// ============================================================================
// Module  : tb_calc_req_scheduler
// Brief   : Scoreboard bench for calc_req_scheduler (GAP_CYCLES=0, TIMEOUT=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_req_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [15:0]  req_cmd = '0;
  logic [127:0] req_op1 = '0;
  logic [127:0] req_op2 = '0;
  logic [3:0]   req_ready;
  logic [37:0]  paket_out;
  logic         rsp_in_valid = 1'b0;
  logic [1:0]   rsp_in_tag = '0;
  logic [1:0]   rsp_in_resp = '0;
  logic [31:0]  rsp_in_data = '0;
  logic [3:0]   rsp_valid;
  logic [7:0]   rsp_resp;
  logic [127:0] rsp_data;
  logic [3:0]   busy;
  logic         stray_rsp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [37:0] bus_q[$];
  logic [35:0] rsp_q[$];

  calc_req_scheduler #(.GAP_CYCLES(0), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .paket_out(paket_out),
    .rsp_in_valid(rsp_in_valid), .rsp_in_tag(rsp_in_tag),
    .rsp_in_resp(rsp_in_resp), .rsp_in_data(rsp_in_data),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .busy(busy), .stray_rsp(stray_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[p]       = v;
    req_cmd[4*p +: 4]  = c;
    req_op1[32*p +: 32] = a;
    req_op2[32*p +: 32] = b;
  endtask

  task automatic push_beats(input logic [31:0] a, input logic [3:0] c,
                            input logic [1:0] g, input logic [31:0] b);
    bus_q.push_back({a, c, g});
    bus_q.push_back({b, 6'h00});
  endtask

  task automatic rsp_drive(input logic [1:0] t, input logic [1:0] r, input logic [31:0] d);
    rsp_in_valid = 1'b1;
    rsp_in_tag   = t;
    rsp_in_resp  = r;
    rsp_in_data  = d;
  endtask

  task automatic rsp_clr();
    rsp_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_clr();
    step();
    step();
    reset = 1'b0;
  endtask

  // Monitor: every non-zero bus beat and every response pulse must match the scoreboard
  always @(negedge clk) begin
    logic [37:0] eb;
    logic [35:0] er;
    if (paket_out != 38'd0) begin
      if (bus_q.size() == 0) chk("bus_extra", {90'd0, paket_out}, 128'd0);
      else begin
        eb = bus_q.pop_front();
        chk("bus_beat", {90'd0, paket_out}, {90'd0, eb});
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (rsp_valid[p]) begin
        if (rsp_q.size() == 0) chk("rsp_extra", 128'(p), 128'hDEAD);
        else begin
          er = rsp_q.pop_front();
          chk("rsp_pulse", {92'd0, 2'(p), rsp_resp[2*p +: 2], rsp_data[32*p +: 32]},
              {92'd0, er});
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    reset = 1'b1;
    step();
    chk("rst_paket", {90'd0, paket_out}, 128'd0);
    chk("rst_busy", {124'd0, busy}, 128'd0);
    chk("rst_rsp_valid", {124'd0, rsp_valid}, 128'd0);
    chk("rst_stray", {127'd0, stray_rsp}, 128'd0);
    chk("rst_ready", {124'd0, req_ready}, 128'd0);
    reset = 1'b0;

    // Single request on port 1
    step();
    set_req(1, 1'b1, 4'h1, 32'd5, 32'd7);
    push_beats(32'd5, 4'h1, 2'd1, 32'd7);
    #1 chk("t1_ready", {124'd0, req_ready}, 128'b0010);
    step();
    set_req(1, 1'b0, 4'h0, 32'd0, 32'd0);
    chk("t1_busy", {124'd0, busy}, 128'b0010);
    step();
    step();
    chk("t1_bus_idle", {90'd0, paket_out}, 128'd0);
    rsp_drive(2'd1, 2'b01, 32'd12);
    rsp_q.push_back({2'd1, 2'b01, 32'd12});
    step();
    rsp_clr();
    chk("t1_busy_clr", {124'd0, busy}, 128'd0);

    // All four requesting, responses returned on each beat1
    do_reset();
    chk("t2_rst_data", rsp_data, 128'd0);
    for (int p = 0; p < 4; p++) set_req(p, 1'b1, 4'(p + 1), 32'h100 + p, 32'h200 + p);
    for (int k = 0; k < 5; k++) begin
      int ep;
      ep = k % 4;
      #1 chk("t2_ready", {124'd0, req_ready}, 128'(4'b0001 << ep));
      push_beats(32'h100 + ep, 4'(ep + 1), 2'(ep), 32'h200 + ep);
      if (k > 0) begin
        rsp_drive(2'((k - 1) % 4), 2'b00, 32'h500 + k);
        rsp_q.push_back({2'((k - 1) % 4), 2'b00, 32'h500 + k});
      end
      step();
      rsp_clr();
      if (k == 4) req_valid = '0;
      #1 chk("t2_no_grant_beat0", {124'd0, req_ready}, 128'd0);
      step();
    end
    rsp_drive(2'd0, 2'b10, 32'h600);
    rsp_q.push_back({2'd0, 2'b10, 32'h600});
    step();
    rsp_clr();
    chk("t2_all_free", {124'd0, busy}, 128'd0);

    // Blocking of a busy port, then a stray response
    do_reset();
    set_req(2, 1'b1, 4'h3, 32'h22, 32'h33);
    #1 chk("t3_ready", {124'd0, req_ready}, 128'b0100);
    push_beats(32'h22, 4'h3, 2'd2, 32'h33);
    for (int i = 0; i < 4; i++) begin
      step();
      #1 chk("t3_blocked", {124'd0, req_ready}, 128'd0);
    end
    step();
    rsp_drive(2'd2, 2'b10, 32'h77);
    rsp_q.push_back({2'd2, 2'b10, 32'h77});
    #1 chk("t3_rsp_cycle", {124'd0, req_ready}, 128'd0);
    step();
    rsp_clr();
    chk("t3_busy_cleared", {124'd0, busy}, 128'd0);
    #1 chk("t3_regrant", {124'd0, req_ready}, 128'b0100);
    push_beats(32'h22, 4'h3, 2'd2, 32'h33);
    step();
    set_req(2, 1'b0, 4'h0, 32'd0, 32'd0);
    step();
    rsp_drive(2'd3, 2'b01, 32'h99);
    step();
    rsp_clr();
    chk("t3_stray", {127'd0, stray_rsp}, 128'd1);
    chk("t3_stray_no_rsp", {124'd0, rsp_valid}, 128'd0);
    rsp_drive(2'd2, 2'b00, 32'h55);
    rsp_q.push_back({2'd2, 2'b00, 32'h55});
    step();
    rsp_clr();
    chk("t3_stray_clr", {127'd0, stray_rsp}, 128'd0);

    // Timeout with no response
    do_reset();
    set_req(0, 1'b1, 4'h5, 32'd1, 32'd2);
    #1 chk("t4_ready", {124'd0, req_ready}, 128'b0001);
    push_beats(32'd1, 4'h5, 2'd0, 32'd2);
    rsp_q.push_back({2'd0, 2'b11, 32'd0});
    step();
    set_req(0, 1'b0, 4'h0, 32'd0, 32'd0);
    repeat (8) step();
    chk("t4_pre_to", {124'd0, rsp_valid}, 128'd0);
    chk("t4_pre_busy", {124'd0, busy}, 128'b0001);
    step();
    chk("t4_to_pulse", {124'd0, rsp_valid}, 128'b0001);
    chk("t4_to_busy", {124'd0, busy}, 128'd0);
    step();
    chk("t4_one_cycle", {124'd0, rsp_valid}, 128'd0);

    // Response on the same cycle the timeout would fire
    do_reset();
    set_req(0, 1'b1, 4'h6, 32'd3, 32'd4);
    #1 chk("t5_ready", {124'd0, req_ready}, 128'b0001);
    push_beats(32'd3, 4'h6, 2'd0, 32'd4);
    step();
    set_req(0, 1'b0, 4'h0, 32'd0, 32'd0);
    repeat (8) step();
    rsp_drive(2'd0, 2'b01, 32'hABCD);
    rsp_q.push_back({2'd0, 2'b01, 32'hABCD});
    step();
    rsp_clr();
    chk("t5_pulse", {124'd0, rsp_valid}, 128'b0001);
    chk("t5_busy", {124'd0, busy}, 128'd0);
    step();
    chk("t5_single", {124'd0, rsp_valid}, 128'd0);

    // Reset while beat0 is on the bus
    do_reset();
    set_req(2, 1'b1, 4'h7, 32'h66, 32'h67);
    #1 chk("t6_ready", {124'd0, req_ready}, 128'b0100);
    bus_q.push_back({32'h66, 4'h7, 2'd2});
    step();
    set_req(2, 1'b0, 4'h0, 32'd0, 32'd0);
    reset = 1'b1;
    step();
    chk("t6_paket_rst", {90'd0, paket_out}, 128'd0);
    chk("t6_busy_rst", {124'd0, busy}, 128'd0);
    reset = 1'b0;
    set_req(3, 1'b1, 4'h8, 32'h88, 32'h89);
    #1 chk("t6_p3_first", {124'd0, req_ready}, 128'b1000);
    push_beats(32'h88, 4'h8, 2'd3, 32'h89);
    step();
    set_req(3, 1'b0, 4'h0, 32'd0, 32'd0);
    step();
    rsp_drive(2'd3, 2'b00, 32'd1);
    rsp_q.push_back({2'd3, 2'b00, 32'd1});
    step();
    rsp_clr();

    // cmd == 0 is never granted
    step();
    set_req(1, 1'b1, 4'h0, 32'h11, 32'h12);
    for (int i = 0; i < 5; i++) begin
      #1 chk("t7_ready", {124'd0, req_ready}, 128'd0);
      step();
      chk("t7_bus", {90'd0, paket_out}, 128'd0);
    end
    chk("t7_busy", {124'd0, busy}, 128'd0);
    set_req(1, 1'b0, 4'h0, 32'd0, 32'd0);
    step();
    step();

    chk("bus_q_drained", 128'(bus_q.size()), 128'd0);
    chk("rsp_q_drained", 128'(rsp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
